// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared state, sweep-result and key-code definitions for the keypad scanner
package keypad_scan_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} sweep_t;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running SCAN_DIV divider emitting a one-cycle column-step tick
// Ports: clk, rst_n (sync, active-low), tick (high during the last divider count)
module keypad_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] div;
  assign tick = div == W'(SCAN_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with sweep-level debounce and one-shot key output
// Ports: clk, rst_n (sync, active-low), i_row (active-low rows), o_col (active-low strobe),
//        o_key_code (row*4+col), o_key_valid (one-cycle press pulse), o_key_held (press..release)
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held
);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
  logic       tick, sweep_end;
  logic [1:0] col, acc_cnt, sum, first_row;
  logic [3:0] acc_code, hit_code, low;
  logic [2:0] tot;
  sweep_t     res;
  state_t     state, state_nx;
  logic [3:0] n, n_nx, cand, cand_nx, code_nx;
  logic       held_nx, valid_nx;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  assign o_col     = ~(4'b0001 << col);
  assign sweep_end = tick && col == 2'd3;
  // Fold the column being sampled into the running sweep totals so the result is
  // available on the same edge that samples column 3.
  always_comb begin
    low       = ~i_row;
    tot       = {1'b0, acc_cnt} + 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    sum       = tot >= 3'd2 ? 2'd2 : tot[1:0];
    first_row = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    hit_code  = (acc_cnt == 2'd0 && |low) ? key_code(first_row, col) : acc_code;
    res       = sum == 2'd0 ? NONE : sum == 2'd1 ? SINGLE : MULTI;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      col      <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (tick) begin
      col      <= col + 2'd1;
      acc_cnt  <= sweep_end ? 2'd0 : sum;
      acc_code <= sweep_end ? 4'd0 : hit_code;
    end

  always_comb begin
    state_nx = state;
    n_nx     = n;
    cand_nx  = cand;
    code_nx  = o_key_code;
    held_nx  = o_key_held;
    valid_nx = 1'b0;
    if (sweep_end) begin
      case (state)
        IDLE:     if (res == SINGLE) begin cand_nx = hit_code; n_nx = 4'd1; state_nx = DEBOUNCE; end
        DEBOUNCE: if (res != SINGLE) begin n_nx = 4'd0; state_nx = IDLE; end
                  else if (hit_code == cand) n_nx = n + 4'd1;
                  else begin cand_nx = hit_code; n_nx = 4'd1; end
        PRESSED:  if (res == NONE) begin n_nx = 4'd1; state_nx = RELEASE; end
        RELEASE:  if (res != NONE) begin n_nx = 4'd0; state_nx = PRESSED; end
                  else n_nx = n + 4'd1;
        default:  state_nx = IDLE;
      endcase
      // Thresholds are tested after the update so DEBOUNCE_SCANS = 1 accepts or
      // releases on the very first qualifying sweep.
      if (state_nx == DEBOUNCE && n_nx == DS) begin
        code_nx  = cand_nx;
        valid_nx = 1'b1;
        held_nx  = 1'b1;
        n_nx     = 4'd0;
        state_nx = PRESSED;
      end else if (state_nx == RELEASE && n_nx == DS) begin
        held_nx  = 1'b0;
        n_nx     = 4'd0;
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      n           <= 4'd0;
      cand        <= 4'd0;
      o_key_code  <= 4'd0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      state       <= state_nx;
      n           <= n_nx;
      cand        <= cand_nx;
      o_key_code  <= code_nx;
      o_key_valid <= valid_nx;
      o_key_held  <= held_nx;
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3)
module tb_keypad_scan;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  i_row, o_col, o_key_code;
  logic        o_key_valid, o_key_held;
  logic [15:0] keys = 16'h0;
  int          tests = 0, fails = 0, cyc = 0, dbl = 0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_row(i_row), .o_col(o_col),
    .o_key_code(o_key_code), .o_key_valid(o_key_valid), .o_key_held(o_key_held)
  );

  always #5 clk = ~clk;

  // Key r*4+c pulls row r low while column c is strobed.
  always_comb begin
    i_row = 4'hf;
    for (int r = 0; r < 4; r++) i_row[r] = ~|(keys[r*4 +: 4] & ~o_col);
  end

  task automatic step();
    logic pv;
    pv = o_key_valid;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pv && o_key_valid) dbl++;
  endtask

  task automatic sweep(input logic [15:0] k, output int np, output bit at_end);
    keys = k; np = 0; at_end = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_key_valid) np++;
      if (i == 15) at_end = o_key_valid;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys = 16'h0; rst_n = 1'b0;
    repeat (3) step();
    tests++; if (o_col !== 4'b1110) begin fails++; $display("FAIL reset_col got %b want 1110", o_col); end
    tests++; if (o_key_code !== 4'd0) begin fails++; $display("FAIL reset_code got %0d want 0", o_key_code); end
    tests++; if (o_key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_key_valid); end
    tests++; if (o_key_held !== 1'b0) begin fails++; $display("FAIL reset_held got %b want 0", o_key_held); end
    rst_n = 1'b1; cyc = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) step();
      exp_col = ~(4'b0001 << ((cyc / 4) % 4));
      tests++; if (o_col !== exp_col) begin fails++; $display("FAIL col_step cyc=%0d got %b want %b", cyc, o_col, exp_col); end
    end
  endtask

  task automatic test_stable_press();
    int np, tot, at; bit e;
    do_reset(); tot = 0; at = 0;
    for (int s = 1; s <= 6; s++) begin
      sweep(16'h1 << 9, np, e);
      tot += np;
      if (e) at = s;
      if (s == 2) begin
        tests++; if (o_key_held !== 1'b0) begin fails++; $display("FAIL stable_held_early got %b want 0", o_key_held); end
      end
    end
    tests++; if (tot !== 1) begin fails++; $display("FAIL stable_pulses got %0d want 1", tot); end
    tests++; if (at !== 3) begin fails++; $display("FAIL stable_pulse_sweep got %0d want 3", at); end
    tests++; if (o_key_code !== 4'd9) begin fails++; $display("FAIL stable_code got %0d want 9", o_key_code); end
    tests++; if (o_key_held !== 1'b1) begin fails++; $display("FAIL stable_held got %b want 1", o_key_held); end
  endtask

  task automatic test_bounce_press();
    int np, tot, at; bit e;
    logic [15:0] pat [5];
    pat = '{16'h0200, 16'h0, 16'h0200, 16'h0200, 16'h0200};
    do_reset(); tot = 0; at = 0;
    for (int s = 1; s <= 5; s++) begin
      sweep(pat[s-1], np, e);
      tot += np;
      if (e) at = s;
    end
    tests++; if (tot !== 1) begin fails++; $display("FAIL bounce_pulses got %0d want 1", tot); end
    tests++; if (at !== 5) begin fails++; $display("FAIL bounce_pulse_sweep got %0d want 5", at); end
    tests++; if (o_key_code !== 4'd9) begin fails++; $display("FAIL bounce_code got %0d want 9", o_key_code); end
  endtask

  task automatic test_release();
    int np, tot; bit e;
    tot = 0;
    sweep(16'h0, np, e); tot += np;
    sweep(16'h0200, np, e); tot += np;
    tests++; if (o_key_held !== 1'b1) begin fails++; $display("FAIL release_glitch_held got %b want 1", o_key_held); end
    sweep(16'h0, np, e); tot += np;
    sweep(16'h0, np, e); tot += np;
    tests++; if (o_key_held !== 1'b1) begin fails++; $display("FAIL release_held_2 got %b want 1", o_key_held); end
    sweep(16'h0, np, e); tot += np;
    tests++; if (o_key_held !== 1'b0) begin fails++; $display("FAIL release_held_3 got %b want 0", o_key_held); end
    tests++; if (tot !== 0) begin fails++; $display("FAIL release_pulses got %0d want 0", tot); end
  endtask

  task automatic test_multi();
    int np, tot, at; bit e;
    do_reset(); tot = 0; at = 0;
    for (int s = 1; s <= 4; s++) begin sweep(16'h8001, np, e); tot += np; end
    tests++; if (tot !== 0) begin fails++; $display("FAIL multi_pulses got %0d want 0", tot); end
    tests++; if (o_key_held !== 1'b0) begin fails++; $display("FAIL multi_held got %b want 0", o_key_held); end
    tot = 0;
    for (int s = 1; s <= 3; s++) begin
      sweep(16'h8000, np, e);
      tot += np;
      if (e) at = s;
    end
    tests++; if (tot !== 1) begin fails++; $display("FAIL multi_after_pulses got %0d want 1", tot); end
    tests++; if (at !== 3) begin fails++; $display("FAIL multi_after_sweep got %0d want 3", at); end
    tests++; if (o_key_code !== 4'd15) begin fails++; $display("FAIL multi_code got %0d want 15", o_key_code); end
  endtask

  task automatic test_mid_reset();
    int np, tot, at; bit e;
    do_reset(); tot = 0; at = 0;
    sweep(16'h0020, np, e); tot += np;
    sweep(16'h0020, np, e); tot += np;
    for (int i = 0; i < 8; i++) begin step(); if (o_key_valid) tot++; end
    rst_n = 1'b0; step(); rst_n = 1'b1; cyc = 0;
    tests++; if (o_col !== 4'b1110) begin fails++; $display("FAIL midrst_col got %b want 1110", o_col); end
    tests++; if (o_key_held !== 1'b0) begin fails++; $display("FAIL midrst_held got %b want 0", o_key_held); end
    for (int s = 1; s <= 3; s++) begin
      sweep(16'h0020, np, e);
      tot += np;
      if (e) at = s;
    end
    tests++; if (tot !== 1) begin fails++; $display("FAIL midrst_pulses got %0d want 1", tot); end
    tests++; if (at !== 3) begin fails++; $display("FAIL midrst_sweep got %0d want 3", at); end
    tests++; if (o_key_code !== 4'd5) begin fails++; $display("FAIL midrst_code got %0d want 5", o_key_code); end
  endtask

  initial begin
    test_reset();
    test_stable_press();
    test_bounce_press();
    test_release();
    test_multi();
    test_mid_reset();
    tests++; if (dbl !== 0) begin fails++; $display("FAIL valid_double got %0d want 0", dbl); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
